// File: rtl/pid_pkg.sv
// Shared definitions for the PID/motor path: FSM state encoding and the
// saturating signed-to-magnitude conversion used by the driver and the PID.
package pid_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DEAD = 2'd2;

   // |value| for a width-bit two's-complement number held sign-extended in 32 bits;
   // the most negative code saturates to the largest positive magnitude.
   function automatic logic [31:0] sat_mag(input logic signed [31:0] value, input int width);
      logic signed [31:0] most_neg;
      logic [31:0]        result;
      most_neg = -(32'sd1 <<< (width - 1));
      if (value == most_neg) begin
         result = (32'd1 << (width - 1)) - 32'd1;
      end else if (value < 32'sd0) begin
         result = -value;
      end else begin
         result = value;
      end
      return result;
   endfunction

endpackage

// File: rtl/pwm_counter.sv
// PWM period counter: counts 0..period while the driver stays in RUN, flags the
// boundary cycle (counter >= period) and registers it as period_tick.
module pwm_counter
   import pid_pkg::*;
#(
   parameter int PERIOD_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    run,
   input  logic                    run_next,
   input  logic [PERIOD_WIDTH-1:0] period,
   output logic [PERIOD_WIDTH-1:0] count,
   output logic                    boundary,
   output logic                    period_tick
);

   logic [PERIOD_WIDTH-1:0] count_d, count_q;
   logic                    tick_d, tick_q;

   // Boundary detect; the counter is held at 0 unless RUN continues into the next cycle.
   always_comb begin
      boundary = run && (count_q >= period);
      tick_d   = boundary;
      if (!run || !run_next || boundary) begin
         count_d = '0;
      end else begin
         count_d = count_q + PERIOD_WIDTH'(1);
      end
   end

   // Counter and tick registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         tick_q  <= tick_d;
      end
   end

   assign count       = count_q;
   assign period_tick = tick_q;

endmodule

// File: rtl/pwm_motor_driver.sv
// H-bridge PWM driver: signed command -> direction + duty, applied at period
// boundaries, with dead time on reversal. dir and state_o come straight from the state flops.
module pwm_motor_driver
   import pid_pkg::*;
#(
   parameter int CMD_WIDTH      = 16,
   parameter int PERIOD_WIDTH   = 16,
   parameter int DEADTIME_WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic signed [CMD_WIDTH-1:0] cmd,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [PERIOD_WIDTH-1:0]     period,
   input  logic [DEADTIME_WIDTH-1:0]   deadtime,
   output logic                        pwm_a,
   output logic                        pwm_b,
   output logic                        dir,
   output logic                        period_tick,
   output logic [1:0]                  state_o
);

   localparam int DUTY_W = PERIOD_WIDTH + 1;
   localparam int CLIP_W = (CMD_WIDTH > DUTY_W) ? CMD_WIDTH : DUTY_W;
   localparam int DT_W   = DEADTIME_WIDTH + 1;

   logic [1:0]                state_d, state_q;
   logic                      dir_d, dir_q;
   logic [DUTY_W-1:0]         duty_d, duty_q;
   logic                      pend_full_d, pend_full_q;
   logic                      pend_sign_d, pend_sign_q;
   logic [CMD_WIDTH-1:0]      pend_mag_d, pend_mag_q;
   logic [DEADTIME_WIDTH-1:0] dead_cnt_d, dead_cnt_q;
   logic                      ready_d, ready_q;
   logic                      pwm_a_d, pwm_a_q;
   logic                      pwm_b_d, pwm_b_q;

   logic [PERIOD_WIDTH-1:0]   count;
   logic                      boundary;
   logic                      accept;
   logic                      pend_load;
   logic                      dead_done;
   logic [CMD_WIDTH-1:0]      cmd_mag;
   logic [CLIP_W-1:0]         mag_ext, lim_ext;
   logic [DUTY_W-1:0]         load_duty;

   pwm_counter #(
      .PERIOD_WIDTH (PERIOD_WIDTH)
   ) u_counter (
      .clk         (clk),
      .reset       (reset),
      .run         (state_q == ST_RUN),
      .run_next    (state_d == ST_RUN),
      .period      (period),
      .count       (count),
      .boundary    (boundary),
      .period_tick (period_tick)
   );

   assign accept    = cmd_valid && !pend_full_q;
   assign cmd_mag   = CMD_WIDTH'(sat_mag(32'(cmd), CMD_WIDTH));
   assign dead_done = ({1'b0, dead_cnt_q} + DT_W'(1)) >= {1'b0, deadtime};

   // Pending magnitude clipped to one full period (duty >= period+1 means always on).
   always_comb begin
      mag_ext = CLIP_W'(pend_mag_q);
      lim_ext = CLIP_W'(period) + CLIP_W'(1);
      if (mag_ext > lim_ext) begin
         load_duty = DUTY_W'(lim_ext);
      end else begin
         load_duty = DUTY_W'(mag_ext);
      end
   end

   // Main FSM: loads pending at boundaries, routes reversals through DEAD.
   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      duty_d     = duty_q;
      dead_cnt_d = dead_cnt_q;
      pend_load  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            duty_d = '0;
            if (enable) begin
               state_d = ST_RUN;
               if (pend_full_q) begin
                  // legs are already low, so a reversal needs no dead time here
                  dir_d     = pend_sign_q;
                  duty_d    = load_duty;
                  pend_load = 1'b1;
               end else begin
                  duty_d = '0;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!enable) begin
               state_d = ST_IDLE;
               duty_d  = '0;
            end else if (boundary && pend_full_q) begin
               if ((pend_mag_q == '0) || (pend_sign_q == dir_q)) begin
                  duty_d    = load_duty;
                  pend_load = 1'b1;
               end else if (deadtime == '0) begin
                  dir_d     = pend_sign_q;
                  duty_d    = load_duty;
                  pend_load = 1'b1;
               end else begin
                  state_d    = ST_DEAD;
                  dead_cnt_d = '0;
               end
            end else begin
               dead_cnt_d = '0;
            end
         end
         ST_DEAD: begin
            if (!enable) begin
               state_d = ST_IDLE;
               duty_d  = '0;
            end else if (dead_done) begin
               state_d   = ST_RUN;
               dir_d     = pend_sign_q;
               duty_d    = load_duty;
               pend_load = 1'b1;
            end else begin
               dead_cnt_d = dead_cnt_q + DEADTIME_WIDTH'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            duty_d  = '0;
         end
      endcase
   end

   // Single-entry pending slot; accept and load are mutually exclusive by construction.
   always_comb begin
      pend_sign_d = pend_sign_q;
      pend_mag_d  = pend_mag_q;
      if (accept) begin
         pend_full_d = 1'b1;
         pend_sign_d = cmd[CMD_WIDTH-1];
         pend_mag_d  = cmd_mag;
      end else if (pend_load) begin
         pend_full_d = 1'b0;
      end else begin
         pend_full_d = pend_full_q;
      end
   end

   // Registered leg drives and handshake.
   always_comb begin
      pwm_a_d = (state_q == ST_RUN) && !dir_q && ({1'b0, count} < duty_q);
      pwm_b_d = (state_q == ST_RUN) &&  dir_q && ({1'b0, count} < duty_q);
      ready_d = !pend_full_d;
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         dir_q       <= 1'b0;
         duty_q      <= '0;
         pend_full_q <= 1'b0;
         pend_sign_q <= 1'b0;
         pend_mag_q  <= '0;
         dead_cnt_q  <= '0;
         ready_q     <= 1'b1;
         pwm_a_q     <= 1'b0;
         pwm_b_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         duty_q      <= duty_d;
         pend_full_q <= pend_full_d;
         pend_sign_q <= pend_sign_d;
         pend_mag_q  <= pend_mag_d;
         dead_cnt_q  <= dead_cnt_d;
         ready_q     <= ready_d;
         pwm_a_q     <= pwm_a_d;
         pwm_b_q     <= pwm_b_d;
      end
   end

   assign cmd_ready = ready_q;
   assign pwm_a     = pwm_a_q;
   assign pwm_b     = pwm_b_q;
   assign dir       = dir_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_pwm_motor_driver.sv
// Bench for pwm_motor_driver: a cycle model pushes expected outputs to a queue
// each cycle; they are popped and compared after the edge, plus directed window counts.
module tb_pwm_motor_driver;

   typedef struct packed {
      logic       pa;
      logic       pb;
      logic       tick;
      logic       dir;
      logic       ready;
      logic [1:0] st;
   } exp_t;

   logic               clk = 1'b0;
   logic               reset;
   logic               enable;
   logic signed [15:0] cmd;
   logic               cmd_valid;
   logic               cmd_ready;
   logic [15:0]        period;
   logic [7:0]         deadtime;
   logic               pwm_a, pwm_b, dir, period_tick;
   logic [1:0]         state_o;

   exp_t               exp_q[$];
   logic signed [15:0] cmd_q[$];

   int n_chk = 0, n_err = 0;
   int sa, sb, st, both_cnt = 0, dead_seen = 0;

   int m_state = 0, m_cnt = 0, m_duty = 0, m_pmag = 0, m_dead = 0;
   bit m_dir = 1'b0, m_pfull = 1'b0, m_psign = 1'b0;

   pwm_motor_driver #(
      .CMD_WIDTH      (16),
      .PERIOD_WIDTH   (16),
      .DEADTIME_WIDTH (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .cmd         (cmd),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .period      (period),
      .deadtime    (deadtime),
      .pwm_a       (pwm_a),
      .pwm_b       (pwm_b),
      .dir         (dir),
      .period_tick (period_tick),
      .state_o     (state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   // Reference model: advances one clock with the inputs currently driven.
   task automatic model_step();
      exp_t e;
      int   c, pr, dt, lim, ns, nduty, mag;
      bit   run, bnd, nd, nf;
      pr = int'(period);
      dt = int'(deadtime);
      e  = '0;
      if (reset) begin
         m_state = 0; m_cnt = 0; m_duty = 0; m_dead = 0;
         m_dir = 1'b0; m_pfull = 1'b0;
         e.ready = 1'b1;
      end else begin
         c   = m_cnt;
         run = (m_state == 1);
         bnd = run && (c >= pr);
         e.pa   = run && !m_dir && (c < m_duty);
         e.pb   = run &&  m_dir && (c < m_duty);
         e.tick = bnd;
         lim   = (m_pmag > pr + 1) ? pr + 1 : m_pmag;
         ns    = m_state;
         nd    = m_dir;
         nduty = m_duty;
         nf    = m_pfull;
         case (m_state)
            0: if (enable) begin
                  ns = 1;
                  if (m_pfull) begin nd = m_psign; nduty = lim; nf = 1'b0; end
               end
            1: if (!enable) begin
                  ns = 0; nduty = 0;
               end else if (bnd && m_pfull) begin
                  if (m_pmag == 0 || m_psign == m_dir) begin nduty = lim; nf = 1'b0; end
                  else if (dt == 0) begin nd = !m_dir; nduty = lim; nf = 1'b0; end
                  else begin ns = 2; m_dead = 0; end
               end
            default: if (!enable) begin
                  ns = 0; nduty = 0;
               end else if (m_dead + 1 >= dt) begin
                  ns = 1; nd = !m_dir; nduty = lim; nf = 1'b0;
               end else begin
                  m_dead = m_dead + 1;
               end
         endcase
         if (cmd_valid && !m_pfull) begin
            mag = int'(cmd);
            if (mag < 0) mag = (mag == -32768) ? 32767 : -mag;
            nf      = 1'b1;
            m_psign = cmd[15];
            m_pmag  = mag;
         end
         m_cnt   = (run && ns == 1 && !bnd) ? c + 1 : 0;
         m_state = ns;
         m_dir   = nd;
         m_duty  = nduty;
         m_pfull = nf;
         e.dir   = nd;
         e.ready = !nf;
         e.st    = ns[1:0];
      end
      exp_q.push_back(e);
   endtask

   task automatic step();
      exp_t got, want;
      logic acc;
      acc = cmd_valid && cmd_ready && !reset;
      model_step();
      @(posedge clk);
      @(negedge clk);
      got  = {pwm_a, pwm_b, period_tick, dir, cmd_ready, state_o};
      want = exp_q.pop_front();
      chk("cycle", 32'(got), 32'(want));
      sa += int'(pwm_a);
      sb += int'(pwm_b);
      st += int'(period_tick);
      if (pwm_a && pwm_b) both_cnt++;
      if (state_o == 2'd2) dead_seen++;
      if (acc) begin
         if (cmd_q.size() > 0) cmd = cmd_q.pop_front();
         else cmd_valid = 1'b0;
      end else if (!cmd_valid && cmd_q.size() > 0) begin
         cmd       = cmd_q.pop_front();
         cmd_valid = 1'b1;
      end
   endtask

   task automatic measure(input int n);
      sa = 0; sb = 0; st = 0;
      repeat (n) step();
   endtask

   task automatic wait_tick(input int bound);
      int   n;
      logic seen;
      n = 0; seen = 1'b0;
      while (!seen && n < bound) begin
         step();
         n++;
         seen = period_tick;
      end
      chk("wait_tick", 32'(seen), 32'd1);
   endtask

   task automatic wait_state(input logic [1:0] s, input int bound);
      int n;
      n = 0;
      while (state_o != s && n < bound) begin
         step();
         n++;
      end
      chk("wait_state", 32'(state_o), 32'(s));
   endtask

   // Queue a command, then measure the second full period after it takes effect.
   task automatic apply(input logic signed [15:0] c);
      cmd_q.push_back(c);
      wait_tick(40);
      wait_tick(40);
      measure(10);
   endtask

   initial begin
      int dlen;
      reset = 1'b1; enable = 1'b0; cmd = '0; cmd_valid = 1'b0;
      period = 16'd9; deadtime = 8'd3;
      step(); step();
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_outs", 32'({pwm_a, pwm_b, period_tick, dir}), 32'd0);

      reset = 1'b0; enable = 1'b1;
      step();
      apply(16'sd4);
      chk("fwd4_a", 32'(sa), 32'd4);
      chk("fwd4_b", 32'(sb), 32'd0);
      chk("fwd4_tick", 32'(st), 32'd1);
      chk("fwd4_dir", 32'(dir), 32'd0);

      // reversal with dead time
      cmd_q.push_back(-16'sd6);
      wait_state(2'd2, 40);
      dlen = 0;
      while (state_o == 2'd2 && dlen < 20) begin
         dlen++;
         step();
      end
      chk("dead_len", 32'(dlen), 32'd3);
      wait_tick(40);
      measure(10);
      chk("rev6_b", 32'(sb), 32'd6);
      chk("rev6_a", 32'(sa), 32'd0);
      chk("rev6_dir", 32'(dir), 32'd1);

      apply(16'sd20);
      chk("clip20_a", 32'(sa), 32'd10);
      apply(-16'sd32768);
      chk("mostneg_b", 32'(sb), 32'd10);
      chk("mostneg_dir", 32'(dir), 32'd1);
      apply(16'sd0);
      chk("zero_ab", 32'(sa + sb), 32'd0);
      chk("zero_dir", 32'(dir), 32'd1);
      apply(16'sd20);
      chk("fwd20_a", 32'(sa), 32'd10);

      // back-to-back commands held on cmd_valid mid-period
      wait_tick(40);
      repeat (3) step();
      cmd_q.push_back(16'sd2);
      cmd_q.push_back(16'sd7);
      step(); step();
      chk("bb_ready", 32'(cmd_ready), 32'd0);
      chk("bb_valid", 32'(cmd_valid), 32'd1);
      wait_tick(40);
      measure(10);
      chk("bb_p1_a", 32'(sa), 32'd2);
      measure(10);
      chk("bb_p2_a", 32'(sa), 32'd7);
      chk("bb_p2_tick", 32'(st), 32'd1);

      // period lowered while counter = 6
      repeat (6) step();
      period = 16'd3;
      step();
      chk("plow_tick", 32'(period_tick), 32'd1);
      measure(12);
      chk("plow_ticks", 32'(st), 32'd3);
      chk("plow_a", 32'(sa), 32'd12);
      period = 16'd9;
      wait_tick(40);

      // disable during DEAD keeps pending, re-enable loads it without dead time
      cmd_q.push_back(-16'sd6);
      wait_state(2'd2, 40);
      enable = 1'b0;
      step();
      chk("dis_state", 32'(state_o), 32'd0);
      chk("dis_ready", 32'(cmd_ready), 32'd0);
      chk("dis_pwm", 32'({pwm_a, pwm_b}), 32'd0);
      enable = 1'b1;
      step();
      chk("reen_state", 32'(state_o), 32'd1);
      chk("reen_dir", 32'(dir), 32'd1);
      wait_tick(40);
      measure(10);
      chk("reen_b", 32'(sb), 32'd6);

      // reset mid-period with a pending command
      wait_tick(40);
      step();
      cmd_q.push_back(16'sd3);
      step(); step();
      chk("prerst_ready", 32'(cmd_ready), 32'd0);
      chk("prerst_b", 32'(pwm_b), 32'd1);
      reset = 1'b1;
      step();
      chk("mrst_outs", 32'({pwm_a, pwm_b, period_tick, dir}), 32'd0);
      chk("mrst_state", 32'(state_o), 32'd0);
      chk("mrst_ready", 32'(cmd_ready), 32'd1);
      reset = 1'b0;

      // zero dead time: direct reversal
      deadtime = 8'd0;
      apply(16'sd5);
      chk("dt0_fwd_a", 32'(sa), 32'd5);
      dead_seen = 0;
      apply(-16'sd5);
      chk("dt0_rev_b", 32'(sb), 32'd5);
      chk("dt0_dead", 32'(dead_seen), 32'd0);

      chk("never_both", 32'(both_cnt), 32'd0);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
